uart_tx_queue: RTL

- Downstream stage of the character generators.
- Accepts bytes on a valid/ready stream, buffers them in a FIFO, and drives the board UART transmit pins `txdata` and `txclk`.
- Paces output on `txready` and emits exactly one `txclk` strobe per byte, so producers no longer toggle `txclk` every cycle.
- Instantiated in `top` between a byte producer and the UART port.

---
 rtl/uart_tx_queue.sv | 104 ++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO feeding the board UART with one txclk strobe per byte
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          txready,
  output logic [7:0]    txdata,
  output logic          txclk,
  output logic [AW:0]   level,
  output logic          busy
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Full is judged from the registered occupancy only, so in_ready never depends on in_valid.
  assign in_ready = (level != FULL_LEVEL);
  assign push     = in_valid && in_ready;
  // A byte leaves the FIFO only when the idle FSM commits it to the UART.
  assign pop      = (state == IDLE) && (level != '0) && txready;
  assign busy     = (state != IDLE) || (level != '0);

  // Storage array; contents need no reset because level guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally at AW bits; occupancy is tracked separately so full and empty differ.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Four-phase transmit sequence: latch byte, settle, single strobe, recover.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      txdata <= 8'h00;
      txclk  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          txclk <= 1'b0;
          if (pop) begin
            txdata <= mem[rd_ptr];
            state  <= SETUP;
          end
        end
        SETUP: begin
          txclk <= 1'b1;
          state <= STROBE;
        end
        STROBE: begin
          txclk <= 1'b0;
          state <= RECOVER;
        end
        RECOVER: begin
          txclk <= 1'b0;
          state <= IDLE;
        end
        default: begin
          txclk <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
